// File: rtl/mme_ho_ctrl.sv
// MME-side handover controller: round-robin arbitration of BS handover requests,
// prepare/ack handshake with the target BS, then serving-BS retarget and source release.
module mme_ho_ctrl #(
   parameter int unsigned TIMEOUT = 8,
   parameter int unsigned INIT_BS = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] ho_req,
   input  logic [5:0] ho_tgt,
   output logic [2:0] ho_gnt,
   output logic [2:0] prep_req,
   input  logic [2:0] prep_ack,
   output logic [2:0] rel_req,
   output logic [1:0] sv_target,
   output logic       ho_done,
   output logic       ho_fail,
   output logic       busy
);

   localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);
   localparam logic [1:0] InitBs     = 2'(INIT_BS);

   typedef enum logic [2:0] {StIdle, StCheck, StPrep, StSwitch, StRel} state_t;

   state_t     state_q;
   logic [1:0] ptr_q;
   logic [1:0] src_q;
   logic [1:0] tgt_q;
   logic [7:0] timer_q;

   logic       win_valid;
   logic [1:0] win;
   logic [1:0] idx;
   logic [1:0] req_tgt;
   logic [7:0] timer_inc;
   logic       reject;
   logic       ack_hit;

   function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] i);
      return 3'b001 << i;
   endfunction

   // First requester at or after the pointer, wrapping mod 3.
   always_comb begin
      win_valid = 1'b0;
      win       = 2'd0;
      idx       = 2'd0;
      for (int k = 0; k < 3; k++) begin
         idx = mod3_add(ptr_q, 2'(k));
         if (!win_valid && ho_req[idx]) begin
            win_valid = 1'b1;
            win       = idx;
         end
      end
   end

   always_comb begin
      req_tgt   = ho_tgt[{win, 1'b0} +: 2];
      timer_inc = timer_q + 8'd1;
      reject    = (tgt_q == 2'd3) || (tgt_q == src_q) || (src_q != sv_target);
      ack_hit   = |(prep_ack & onehot(tgt_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         ptr_q     <= 2'd0;
         src_q     <= 2'd0;
         tgt_q     <= 2'd0;
         timer_q   <= 8'd0;
         ho_gnt    <= 3'b000;
         prep_req  <= 3'b000;
         rel_req   <= 3'b000;
         sv_target <= InitBs;
         ho_done   <= 1'b0;
         ho_fail   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ho_gnt  <= 3'b000;
         rel_req <= 3'b000;
         ho_done <= 1'b0;
         ho_fail <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (win_valid) begin
                  src_q   <= win;
                  tgt_q   <= req_tgt;
                  ho_gnt  <= onehot(win);
                  ptr_q   <= mod3_add(win, 2'd1);
                  state_q <= StCheck;
                  busy    <= 1'b1;
               end
            end
            StCheck: begin
               if (reject) begin
                  ho_fail <= 1'b1;
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  prep_req <= onehot(tgt_q);
                  timer_q  <= 8'd0;
                  state_q  <= StPrep;
               end
            end
            StPrep: begin
               // Ack is tested before the limit so a last-cycle ack still succeeds.
               if (ack_hit) begin
                  prep_req <= 3'b000;
                  state_q  <= StSwitch;
               end else if (timer_inc >= TimeoutLim) begin
                  timer_q  <= timer_inc;
                  prep_req <= 3'b000;
                  ho_fail  <= 1'b1;
                  state_q  <= StIdle;
                  busy     <= 1'b0;
               end else begin
                  timer_q <= timer_inc;
               end
            end
            StSwitch: begin
               sv_target <= tgt_q;
               rel_req   <= onehot(src_q);
               ho_done   <= 1'b1;
               state_q   <= StRel;
            end
            StRel: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               prep_req <= 3'b000;
               state_q  <= StIdle;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mme_ho_ctrl.sv
// Bench for mme_ho_ctrl: table of single-request handovers plus hand-written sequences;
// every pulse output is matched against a queue of expected events with exact cycles.
module tb_mme_ho_ctrl;

   localparam int unsigned Tmo = 8;
   localparam int KRej = 0, KOk = 1, KTmo = 2;

   logic       clk;
   logic       reset;
   logic [2:0] ho_req;
   logic [5:0] ho_tgt;
   logic [2:0] ho_gnt;
   logic [2:0] prep_req;
   logic [2:0] prep_ack;
   logic [2:0] rel_req;
   logic [1:0] sv_target;
   logic       ho_done;
   logic       ho_fail;
   logic       busy;

   mme_ho_ctrl #(.TIMEOUT(Tmo), .INIT_BS(0)) dut (
      .clk       (clk),
      .reset     (reset),
      .ho_req    (ho_req),
      .ho_tgt    (ho_tgt),
      .ho_gnt    (ho_gnt),
      .prep_req  (prep_req),
      .prep_ack  (prep_ack),
      .rel_req   (rel_req),
      .sv_target (sv_target),
      .ho_done   (ho_done),
      .ho_fail   (ho_fail),
      .busy      (busy)
   );

   typedef struct {
      logic [2:0] gnt;
      logic       fail;
      logic       done;
      logic [2:0] rel;
      logic [1:0] sv;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [2:0] req;
      logic [5:0] tgt;
      int         kind;
      int         dly;
      logic [2:0] ack;
      logic [2:0] prep;
      int         plen;
      logic [1:0] sv;
   } vec_t;

   ev_t        exp_q[$];
   vec_t       tbl[8];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic [1:0] cur_sv;
   ev_t        mon_e;
   logic [9:0] mon_act;
   logic [9:0] mon_exp;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic ok, input int act, input int exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk_ev(input logic [2:0] gnt, input logic fail, input logic done,
                                 input logic [2:0] rel, input logic [1:0] sv, input int c);
      ev_t e;
      e.gnt  = gnt;
      e.fail = fail;
      e.done = done;
      e.rel  = rel;
      e.sv   = sv;
      e.cyc  = c;
      return e;
   endfunction

   // Scoreboard: any pulse output must match the next expected event exactly.
   always @(negedge clk) begin
      if (ho_gnt != 3'b000 || ho_fail || ho_done || rel_req != 3'b000) begin
         mon_act = {ho_gnt, ho_fail, ho_done, rel_req, sv_target};
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1'b0, int'(mon_act), 0);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_exp = {mon_e.gnt, mon_e.fail, mon_e.done, mon_e.rel, mon_e.sv};
            chk("pulse_outputs", mon_act == mon_exp, int'(mon_act), int'(mon_exp));
            chk("pulse_cycle", cyc == mon_e.cyc, cyc, mon_e.cyc);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      cur_sv = 2'd0;
   endtask

   task automatic run_vec(input vec_t v);
      int c, pcnt, n;
      c = cyc;
      ho_req = v.req;
      ho_tgt = v.tgt;
      exp_q.push_back(mk_ev(v.req, 1'b0, 1'b0, 3'b000, cur_sv, c + 1));
      case (v.kind)
         KRej:    exp_q.push_back(mk_ev(3'b000, 1'b1, 1'b0, 3'b000, cur_sv, c + 2));
         KTmo:    exp_q.push_back(mk_ev(3'b000, 1'b1, 1'b0, 3'b000, cur_sv, c + 2 + Tmo));
         default: exp_q.push_back(mk_ev(3'b000, 1'b0, 1'b1, v.req, v.sv, c + 4 + v.dly));
      endcase
      @(negedge clk);
      ho_req = 3'b000;
      pcnt = 0;
      n = 0;
      while (n < 40 && (busy || cyc <= c + 2)) begin
         if (cyc == c + 2 + v.dly) prep_ack = v.ack;
         if (prep_req != 3'b000) begin
            pcnt++;
            chk("prep_req_value", prep_req == v.prep, int'(prep_req), int'(v.prep));
         end
         @(negedge clk);
         n++;
      end
      prep_ack = 3'b000;
      chk("busy_bound", n < 40, n, 40);
      chk("prep_req_cycles", pcnt == v.plen, pcnt, v.plen);
      chk("sv_target_after", sv_target == v.sv, int'(sv_target), int'(v.sv));
      chk("busy_low_after", busy == 1'b0, int'(busy), 0);
      cur_sv = v.sv;
   endtask

   initial begin
      int c;
      //            req     tgt         kind  dly ack     prep    plen sv
      tbl[0] = '{3'b100, 6'b010000, KRej, 0, 3'b000, 3'b000, 0, 2'd0}; // BS3 not serving
      tbl[1] = '{3'b001, 6'b000001, KOk,  2, 3'b010, 3'b010, 3, 2'd1}; // basic BS1->BS2
      tbl[2] = '{3'b010, 6'b001100, KRej, 0, 3'b000, 3'b000, 0, 2'd1}; // tgt=3
      tbl[3] = '{3'b010, 6'b000100, KRej, 0, 3'b000, 3'b000, 0, 2'd1}; // tgt==src
      tbl[4] = '{3'b010, 6'b001000, KTmo, 0, 3'b000, 3'b100, 8, 2'd1}; // no ack
      tbl[5] = '{3'b010, 6'b001000, KTmo, 0, 3'b011, 3'b100, 8, 2'd1}; // wrong ack bits
      tbl[6] = '{3'b010, 6'b001000, KOk,  7, 3'b100, 3'b100, 8, 2'd2}; // ack on 8th cycle
      tbl[7] = '{3'b100, 6'b000000, KOk,  0, 3'b001, 3'b001, 1, 2'd0}; // best case

      reset    = 1'b1;
      ho_req   = 3'b000;
      ho_tgt   = 6'b000000;
      prep_ack = 3'b000;
      cur_sv   = 2'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {ho_gnt, prep_req, rel_req, ho_done, ho_fail, busy} == 12'd0,
          int'({ho_gnt, prep_req, rel_req, ho_done, ho_fail, busy}), 0);
      chk("reset_sv_target", sv_target == 2'd0, int'(sv_target), 0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // Round-robin: all three held, all rejected via tgt=3.
      do_reset();
      c = cyc;
      ho_req = 3'b111;
      ho_tgt = 6'b111111;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk_ev(3'b001 << (i % 3), 1'b0, 1'b0, 3'b000, 2'd0, c + 1 + 2 * i));
         exp_q.push_back(mk_ev(3'b000, 1'b1, 1'b0, 3'b000, 2'd0, c + 2 + 2 * i));
      end
      repeat (7) @(negedge clk);
      ho_req = 3'b000;
      repeat (3) @(negedge clk);
      chk("rr_busy_low", busy == 1'b0, int'(busy), 0);
      chk("rr_sv_target", sv_target == 2'd0, int'(sv_target), 0);

      // Back-to-back chain BS1->BS2 then BS2->BS3; second request held while busy.
      do_reset();
      c = cyc;
      ho_req   = 3'b001;
      ho_tgt   = 6'b001001;
      prep_ack = 3'b110;
      exp_q.push_back(mk_ev(3'b001, 1'b0, 1'b0, 3'b000, 2'd0, c + 1));
      exp_q.push_back(mk_ev(3'b000, 1'b0, 1'b1, 3'b001, 2'd1, c + 4));
      exp_q.push_back(mk_ev(3'b010, 1'b0, 1'b0, 3'b000, 2'd1, c + 6));
      exp_q.push_back(mk_ev(3'b000, 1'b0, 1'b1, 3'b010, 2'd2, c + 9));
      @(negedge clk);
      ho_req = 3'b010;
      repeat (5) @(negedge clk);
      ho_req = 3'b000;
      repeat (4) @(negedge clk);
      prep_ack = 3'b000;
      chk("chain_busy_low", busy == 1'b0, int'(busy), 0);
      chk("chain_sv_target", sv_target == 2'd2, int'(sv_target), 2);

      // Reset mid-PREP: aborts silently, restores sv_target and the pointer.
      do_reset();
      run_vec(tbl[1]);
      c = cyc;
      ho_req = 3'b010;
      ho_tgt = 6'b001000;
      exp_q.push_back(mk_ev(3'b010, 1'b0, 1'b0, 3'b000, 2'd1, c + 1));
      @(negedge clk);
      ho_req = 3'b000;
      repeat (3) @(negedge clk);
      chk("midprep_prep_req", prep_req == 3'b100, int'(prep_req), 4);
      reset = 1'b1;
      @(negedge clk);
      chk("midprep_reset_outputs", {ho_gnt, prep_req, rel_req, ho_done, ho_fail, busy} == 12'd0,
          int'({ho_gnt, prep_req, rel_req, ho_done, ho_fail, busy}), 0);
      chk("midprep_sv_target", sv_target == 2'd0, int'(sv_target), 0);
      reset  = 1'b0;
      cur_sv = 2'd0;
      ho_req = 3'b111;
      ho_tgt = 6'b111111;
      exp_q.push_back(mk_ev(3'b001, 1'b0, 1'b0, 3'b000, 2'd0, c + 6));
      exp_q.push_back(mk_ev(3'b000, 1'b1, 1'b0, 3'b000, 2'd0, c + 7));
      @(negedge clk);
      ho_req = 3'b000;
      repeat (3) @(negedge clk);
      chk("midprep_busy_low", busy == 1'b0, int'(busy), 0);

      repeat (2) @(negedge clk);
      chk("events_all_seen", exp_q.size() == 0, exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mme_ho_ctrl.md
# mme_ho_ctrl

Handover controller (MME side) for the three-base-station handover system. It arbitrates handover requests from BS1..BS3 round-robin and runs a prepare/acknowledge handshake with the target BS. On success it retargets the server's downlink routing (`sv_target`, driving the server's BS select) and tells the source BS to release. It owns the single serving-BS register for the UE.

## Interface
Parameters:
- `TIMEOUT`, 8: max cycles in PREP without ack before abort; legal range 1..255.
- `INIT_BS`, 0: serving BS index (0=BS1, 1=BS2, 2=BS3) loaded at reset.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `ho_req`  in  3  bit i = BS(i+1) requests handover; held until granted.
- `ho_tgt`  in  6  requested target index of BS(i+1) in bits [2i+1:2i]; 3 is invalid.
- `ho_gnt`  out  3  one-hot, one-cycle pulse; request i accepted.
- `prep_req`  out  3  one-hot to target BS; held during PREP.
- `prep_ack`  in  3  bit i = BS(i+1) ready to take the UE.
- `rel_req`  out  3  one-hot, one-cycle pulse to the source BS.
- `sv_target`  out  2  serving BS index used by the server for routing.
- `ho_done`  out  1  one-cycle pulse; handover completed.
- `ho_fail`  out  1  one-cycle pulse; handover rejected or timed out.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- All outputs are registered. Reset values:
  - `ho_gnt`, `prep_req`, `rel_req` = 0; `ho_done`, `ho_fail`, `busy` = 0.
  - `sv_target` = INIT_BS; round-robin pointer = 0; state = IDLE; timer = 0.
- FSM states: IDLE, CHECK, PREP, SWITCH, REL.
- IDLE, when `ho_req` != 0:
  - Winner w = first set bit scanning from the pointer upward, mod 3.
  - Latch src=w and tgt=`ho_tgt[2w+1:2w]`; pulse `ho_gnt[w]`.
  - Pointer <= (w+1) mod 3; go to CHECK.
  - Requests are sampled only in IDLE and ignored in all other states.
- CHECK (1 cycle) rejects the request if tgt==3, tgt==src, or src != `sv_target`:
  - On reject: pulse `ho_fail`, go to IDLE.
  - Otherwise: assert `prep_req[tgt]`, clear the timer, go to PREP.
- PREP, each cycle:
  - If `prep_ack[tgt]`: drop `prep_req`, go to SWITCH.
  - Else timer++. When timer reaches TIMEOUT: drop `prep_req`, pulse `ho_fail`, go to IDLE.
  - Ack and the timeout limit in the same cycle: ack wins.
  - `prep_ack` bits other than tgt are ignored.
- SWITCH (1 cycle): `sv_target` <= tgt; pulse `rel_req[src]` and `ho_done`; go to REL.
- REL (1 cycle): outputs from SWITCH are visible here; go to IDLE.
- `sv_target` changes only on SWITCH exit or reset.
- Reset in any state:
  - Aborts the handover without a `ho_fail` or `rel_req` pulse.
  - Restores all reset values on the next edge.

## Timing
- Edge numbering: request present before edge E0.
- E0: `ho_gnt` high (CHECK).
- E1: `prep_req` high (PREP). A reject instead gives `ho_fail` high, state IDLE.
- Ack seen at PREP edge Ek: SWITCH. At Ek+1: new `sv_target`, `rel_req`, and `ho_done` all high in the same cycle (REL). At Ek+2: IDLE.
- Best case, ack already high at E2: request to `sv_target` update takes 4 edges.
- Timeout: `ho_fail` rises TIMEOUT edges after `prep_req` rises. `prep_req` is high exactly TIMEOUT cycles.
- In the cycle `ho_fail` is high the state is IDLE, so a new request may be granted at that same edge.
- Minimum spacing between `ho_gnt` pulses: 2 cycles (reject path), 5 cycles (success).
- `busy` tracks state with no extra latency.

## Test plan
- Basic handover: INIT_BS=0, BS1 requests tgt=1, `prep_ack[1]` returned 2 cycles after `prep_req[1]`.
  - Required: `ho_gnt`=001, then `prep_req`=010, then `sv_target`=1 with `rel_req`=001 and `ho_done` in the same cycle, then `busy` low.
- Round-robin: all three `ho_req` held continuously, all rejected with fast fail.
  - Required: grant order 001, 010, 100, 001, with 2-cycle spacing.
- Rejects, each giving `ho_fail` pulse 1 cycle after `ho_gnt`, no `prep_req`, `sv_target` unchanged:
  - tgt=3.
  - tgt==src.
  - Request from non-serving BS3 while `sv_target`=0.
- Timeout, TIMEOUT=8, no ack: `prep_req[2]` high exactly 8 cycles, then `ho_fail`, `sv_target` unchanged.
  - Repeat with ack on the 8th PREP cycle: must succeed.
  - Ack on a wrong bit only: must time out.
- Reset mid-PREP: assert `reset` during PREP.
  - Required next cycle: all outputs 0, `sv_target`=INIT_BS, no `ho_fail`.
  - A request 1 cycle later is granted from pointer 0.
- Back-to-back chain: BS1→BS2, then BS2→BS3.
  - Required: `sv_target` goes 0→1→2, each change accompanied by one `ho_done` pulse and one correct `rel_req` pulse.
